// File: rtl/glyph_serializer_pkg.sv
// Shared glyph serializer definitions: FSM state encoding, glyph geometry defaults
// and the charIndex bit that selects the blank glyph.
package glyph_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT
  } glyphState_t;

  localparam int GlyphWidthDefault = 8;
  localparam int GlyphRowsDefault  = 16;
  localparam int BlankBit          = 2;

endpackage

// File: rtl/glyph_serializer_pixel_shifter.sv
// Row shift register with pixel counter: loads one ROM row and emits it MSB first, one pixel per shift strobe.
// pixelOut/pixelValid register one cycle after the strobe; there is no backpressure, every strobe is honoured.
module pixel_shifter
  import glyph_serializer_pkg::*;
#(
  parameter int WIDTH = GlyphWidthDefault
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic             shift,
  output logic             pixelOut,
  output logic             pixelValid,
  output logic             lastPixel
);

  localparam int CountWidth = $clog2(WIDTH);

  logic [WIDTH-1:0]      shiftReg;
  logic [CountWidth-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg   <= '0;
      count      <= '0;
      pixelOut   <= 1'b0;
      pixelValid <= 1'b0;
    end else if (clear) begin
      // pixelOut deliberately holds its last value; only the row contents are discarded
      shiftReg   <= '0;
      count      <= '0;
      pixelValid <= 1'b0;
    end else begin
      pixelValid <= shift;
      if (load) begin
        shiftReg <= loadData;
        count    <= '0;
      end else if (shift) begin
        pixelOut <= shiftReg[WIDTH-1];
        shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
        count    <= count + 1'b1;
      end
    end
  end

  assign lastPixel = (count == CountWidth'(WIDTH - 1));

endmodule

// File: rtl/glyph_serializer.sv
// Serializes one character glyph from the character ROM, row by row, MSB first; 10 cycles per row at full pixel rate.
// pixelTick paces the output in SHIFT; start is ignored while busy and abort returns to IDLE on the next edge.
module glyph_serializer
  import glyph_serializer_pkg::*;
#(
  parameter int GLYPH_ROWS  = GlyphRowsDefault,
  parameter int GLYPH_WIDTH = GlyphWidthDefault
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             charIndex,
  input  logic                   abort,
  input  logic                   pixelTick,
  output logic                   romEnable,
  output logic [2:0]             highAddrOffset,
  output logic [3:0]             lowAddrOffset,
  input  logic [GLYPH_WIDTH-1:0] romByte,
  output logic                   pixelOut,
  output logic                   pixelValid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] LastRow = 4'(GLYPH_ROWS - 1);

  glyphState_t state, stateNext;
  logic [3:0]  row, rowNext;
  logic [2:0]  charLatch, charLatchNext;
  logic        doneNext;
  logic        loadRow;
  logic        shiftPixel;
  logic        lastPixel;
  logic [GLYPH_WIDTH-1:0] rowData;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      charLatch <= '0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      row       <= rowNext;
      charLatch <= charLatchNext;
      done      <= doneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    rowNext       = row;
    charLatchNext = charLatch;
    doneNext      = 1'b0;
    loadRow       = 1'b0;
    shiftPixel    = 1'b0;
    if (abort) begin
      stateNext = IDLE;
      rowNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            charLatchNext = charIndex;
            rowNext       = '0;
            stateNext     = FETCH;
          end
        end
        FETCH: stateNext = WAIT;
        WAIT: begin
          loadRow   = 1'b1;
          stateNext = SHIFT;
        end
        SHIFT: begin
          if (pixelTick) begin
            shiftPixel = 1'b1;
            if (lastPixel) begin
              if (row < LastRow) begin
                rowNext   = row + 4'd1;
                stateNext = FETCH;
              end else begin
                rowNext   = '0;
                doneNext  = 1'b1;
                stateNext = IDLE;
              end
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Blank glyphs still issue the ROM read but discard the returned row
  assign rowData = charLatch[BlankBit] ? '0 : romByte;

  pixel_shifter #(
    .WIDTH(GLYPH_WIDTH)
  ) shifter (
    .clock     (clock),
    .reset     (reset),
    .clear     (abort),
    .load      (loadRow),
    .loadData  (rowData),
    .shift     (shiftPixel),
    .pixelOut  (pixelOut),
    .pixelValid(pixelValid),
    .lastPixel (lastPixel)
  );

  assign romEnable      = (state == FETCH);
  assign busy           = (state != IDLE);
  assign highAddrOffset = charLatch;
  assign lowAddrOffset  = row;

endmodule

// File: tb/tb_glyph_serializer.sv
// Bench for glyph_serializer: random ROM contents and pixel-tick patterns checked against a
// row-level timing model and the expected MSB-first pixel stream.
module tb_glyph_serializer;
  import glyph_serializer_pkg::*;

  localparam int Rows    = GlyphRowsDefault;
  localparam int LogSize = 16384;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pixelTick = 1'b0;
  logic [2:0] charIndex = 3'd0;
  logic [7:0] romByte = 8'h00;
  logic       romEnable, pixelOut, pixelValid, busy, done;
  logic [2:0] highAddrOffset;
  logic [3:0] lowAddrOffset;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tickMode = 0;
  bit tickLog [LogSize];
  logic [7:0] rom [64];

  logic       obsPix[$];
  int         obsPixCyc[$];
  logic [5:0] obsAddr[$];
  int         obsFetchCyc[$];
  int         obsDone[$];
  int         expFetch[$];
  int         expPixCyc[$];

  glyph_serializer #(
    .GLYPH_ROWS (Rows),
    .GLYPH_WIDTH(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .charIndex     (charIndex),
    .abort         (abort),
    .pixelTick     (pixelTick),
    .romEnable     (romEnable),
    .highAddrOffset(highAddrOffset),
    .lowAddrOffset (lowAddrOffset),
    .romByte       (romByte),
    .pixelOut      (pixelOut),
    .pixelValid    (pixelValid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Character ROM controller: registered read, data valid the cycle after the enable
  always @(posedge clock) if (romEnable) romByte <= rom[{highAddrOffset[1:0], lowAddrOffset}];

  // pixelTick for the coming edge, logged so the model can replay it
  always @(negedge clock) begin
    case (tickMode)
      0:       pixelTick = 1'b1;
      1:       pixelTick = ((cyc + 1) % 4 == 0);
      default: pixelTick = 1'($urandom_range(0, 1));
    endcase
    if (cyc + 1 < LogSize) tickLog[cyc + 1] = pixelTick;
  end

  always @(negedge clock) begin
    if (pixelValid) begin
      obsPix.push_back(pixelOut);
      obsPixCyc.push_back(cyc);
    end
    if (romEnable) begin
      obsAddr.push_back({highAddrOffset[1:0], lowAddrOffset});
      obsFetchCyc.push_back(cyc);
    end
    if (done) obsDone.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic clearObs();
    obsPix.delete(); obsPixCyc.delete(); obsAddr.delete(); obsFetchCyc.delete(); obsDone.delete();
  endtask

  // Row f: FETCH at f, WAIT at f+1, then the 8th ticking edge after f+2 ends the row.
  function automatic int model(input int k);
    int f, e, n;
    f = k;
    expFetch.delete();
    expPixCyc.delete();
    for (int r = 0; r < Rows; r++) begin
      expFetch.push_back(f);
      n = 0;
      e = f + 2;
      while (n < 8 && e < LogSize - 1) begin
        e++;
        if (tickLog[e]) begin
          n++;
          expPixCyc.push_back(e);
        end
      end
      f = e;
    end
    return f;
  endfunction

  task automatic startGlyph(input logic [2:0] ci, output int k);
    clearObs();
    start = 1'b1;
    charIndex = ci;
    step();
    start = 1'b0;
    charIndex = 3'($urandom);
    k = cyc;
  endtask

  task automatic waitDone(input int limit, output int busyDrops);
    busyDrops = 0;
    for (int i = 0; i < limit && obsDone.size() == 0; i++) begin
      step();
      if (!busy && !done) busyDrops++;
    end
  endtask

  task automatic checkGlyph(input logic [2:0] ci, input int k);
    int doneExp, bad;
    logic [7:0] rowByte;
    doneExp = model(k);
    check("done_count", obsDone.size(), 1);
    check("done_cycle", (obsDone.size() > 0) ? obsDone[0] : -1, doneExp);
    check("fetch_count", obsAddr.size(), Rows);
    bad = 0;
    foreach (obsAddr[i])
      if (obsAddr[i] !== {ci[1:0], 4'(i)} || obsFetchCyc[i] != ((i < expFetch.size()) ? expFetch[i] : -1)) bad++;
    check("fetch_addr_time", bad, 0);
    check("pixel_count", obsPix.size(), Rows * 8);
    bad = 0;
    foreach (obsPix[i]) begin
      rowByte = ci[BlankBit] ? 8'h00 : rom[{ci[1:0], 4'(i / 8)}];
      if (obsPix[i] !== rowByte[7 - i % 8] || obsPixCyc[i] != ((i < expPixCyc.size()) ? expPixCyc[i] : -1)) bad++;
    end
    check("pixel_value_time", bad, 0);
  endtask

  initial begin
    int k, drops, extra;
    logic [2:0] ci;
    logic [7:0] b;

    // Nonzero rows make an all-zero blank glyph distinguishable from real data
    foreach (rom[i]) rom[i] = 8'($urandom) | 8'h01;
    rom[16] = 8'hA5;

    step(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_rom_en", 32'(romEnable), 0);
    check("rst_outputs", 32'({pixelOut, pixelValid, done, highAddrOffset, lowAddrOffset}), 0);
    reset = 1'b0;
    step(2);
    check("idle_after_reset", 32'({busy, romEnable, done}), 0);

    // Single row A5 then the full glyph at full pixel rate
    tickMode = 0;
    startGlyph(3'b001, k);
    check("s1_rom_en_at_k", 32'(romEnable), 1);
    check("s1_rom_addr", 32'({highAddrOffset[1:0], lowAddrOffset}), 16);
    waitDone(400, drops);
    for (int i = 0; i < 8; i++) b[7 - i] = (i < obsPix.size()) ? obsPix[i] : 1'bx;
    check("s1_row0_pixels", 32'(b), 'hA5);
    check("s1_next_rom_en", (obsFetchCyc.size() > 1) ? obsFetchCyc[1] : -1, k + 10);
    check("s2_done_160", (obsDone.size() > 0) ? obsDone[0] - k : -1, 160);
    checkGlyph(3'b001, k);

    // Blank glyph
    startGlyph(3'b100, k);
    waitDone(400, drops);
    checkGlyph(3'b100, k);

    // Slow pixel rate with a stray start mid-glyph
    tickMode = 1;
    startGlyph(3'b011, k);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy) extra++;
    end
    start = 1'b1;
    charIndex = 3'b010;
    step();
    start = 1'b0;
    check("s4_latch_held", 32'(highAddrOffset), 3);
    waitDone(2000, drops);
    check("s4_busy_throughout", drops + extra, 0);
    checkGlyph(3'b011, k);
    step(30);
    check("s4_no_queued_start", obsAddr.size(), Rows);
    check("s4_idle_after", 32'(busy), 0);

    // Abort on pixel 5 of row 7, then a fresh glyph with random pixel ticks
    tickMode = 0;
    startGlyph(3'b010, k);
    while (cyc < k + 76) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s5_abort_idle", 32'(busy), 0);
    check("s5_abort_no_valid", 32'(pixelValid), 0);
    check("s5_abort_row_zero", 32'(lowAddrOffset), 0);
    check("s5_pixels_before_abort", obsPix.size(), 60);
    step(40);
    check("s5_no_done", obsDone.size(), 0);
    tickMode = 2;
    ci = 3'($urandom_range(0, 3));
    startGlyph(ci, k);
    waitDone(2000, drops);
    checkGlyph(ci, k);

    // Reset during WAIT clears outputs without a clock edge
    tickMode = 0;
    startGlyph(3'b001, k);
    step();
    check("s6_in_wait", 32'(busy), 1);
    #1;
    reset = 1'b1;
    #1;
    check("s6_async_busy", 32'(busy), 0);
    check("s6_async_outputs", 32'({romEnable, pixelValid, done, highAddrOffset, lowAddrOffset}), 0);
    step(2);
    reset = 1'b0;
    step(30);
    check("s6_no_done", obsDone.size(), 0);
    check("s6_stays_idle", obsAddr.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
